// File: rtl/soc_riscv_dbg_jtag_tap.sv
// ----------------------------------------------------------------------------
// soc_riscv_dbg_jtag_tap
//   Oversampled IEEE 1149.1 TAP controller. The raw JTAG pins are brought into
//   the clk domain through 2-flop synchronizers. TCK edges are then detected as
//   single-clk pulses, so all TAP logic runs on clk.
//   The block implements:
//     - the 16-state TAP FSM,
//     - an instruction register,
//     - the IDCODE and BYPASS data registers.
//   The DEBUG data register belongs to the downstream debug unit. This block
//   drives it with one-clk capture/shift/update strobes.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   jtag_trstn      raw TAP reset (active-low, async to clk)
//   jtag_tck/tms/tdi raw JTAG inputs (async to clk)
//   jtag_tdo        registered TDO, updated on TCK fall
//   tap_reset       FSM is in Test-Logic-Reset
//   dbg_select      IR holds DEBUG_INSTR
//   dbg_capture_dr/dbg_shift_dr/dbg_update_dr  one-clk debug DR strobes
//   dbg_tdi         TDI bit accompanying dbg_shift_dr
//   dbg_tdo         serial output of the debug DR (LSB)
// ----------------------------------------------------------------------------
module soc_riscv_dbg_jtag_tap #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = 4'b0001,
  parameter logic [IR_WIDTH-1:0]  DEBUG_INSTR  = 4'b1000,
  parameter logic [IR_WIDTH-1:0]  BYPASS_INSTR = 4'b1111
) (
  input  logic clk,
  input  logic rst,
  input  logic jtag_trstn,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic tap_reset,
  output logic dbg_select,
  output logic dbg_capture_dr,
  output logic dbg_shift_dr,
  output logic dbg_update_dr,
  output logic dbg_tdi,
  input  logic dbg_tdo
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  // Synchronizer stages
  logic trstn_m_q, trstn_s_q;
  logic tck_m_q, tck_s_q, tck_d_q;
  logic tms_m_q, tms_s_q;
  logic tdi_m_q, tdi_s_q;

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [31:0]         idcode_sr_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                cap_q, shift_q, upd_q, dbg_tdi_q;

  logic tck_rise, tck_fall;
  logic sel_debug, sel_idcode;

  assign tck_rise   = tck_s_q & ~tck_d_q;
  assign tck_fall   = ~tck_s_q & tck_d_q;
  // The DR select comes from the active IR, never from the shift stage.
  assign sel_debug  = (ir_q == DEBUG_INSTR);
  assign sel_idcode = (ir_q == IDCODE_INSTR);

  // Standard 1149.1 TMS-driven transitions
  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    unique case (s)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      trstn_m_q   <= 1'b1;
      trstn_s_q   <= 1'b1;
      tck_m_q     <= 1'b0;
      tck_s_q     <= 1'b0;
      tck_d_q     <= 1'b0;
      tms_m_q     <= 1'b0;
      tms_s_q     <= 1'b0;
      tdi_m_q     <= 1'b0;
      tdi_s_q     <= 1'b0;
      state_q     <= TLR;
      ir_q        <= IDCODE_INSTR;
      ir_sr_q     <= '0;
      idcode_sr_q <= IDCODE_VALUE;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      cap_q       <= 1'b0;
      shift_q     <= 1'b0;
      upd_q       <= 1'b0;
      dbg_tdi_q   <= 1'b0;
    end else begin
      trstn_m_q <= jtag_trstn;
      trstn_s_q <= trstn_m_q;
      tck_m_q   <= jtag_tck;
      tck_s_q   <= tck_m_q;
      tck_d_q   <= tck_s_q;
      tms_m_q   <= jtag_tms;
      tms_s_q   <= tms_m_q;
      tdi_m_q   <= jtag_tdi;
      tdi_s_q   <= tdi_m_q;

      // Strobes are single-cycle; the TCK phase constraint keeps them apart.
      cap_q     <= 1'b0;
      shift_q   <= 1'b0;
      upd_q     <= 1'b0;
      dbg_tdi_q <= tdi_s_q;

      if (!trstn_s_q) begin
        // TAP reset overrides any coincident TCK edge.
        state_q <= TLR;
        ir_q    <= IDCODE_INSTR;
        tdo_q   <= 1'b0;
      end else begin
        if (state_q == TLR) begin
          ir_q <= IDCODE_INSTR;
        end
        if (tck_rise) begin
          unique case (state_q)
            CAP_IR:   ir_sr_q <= IR_WIDTH'(2'b01);
            SHIFT_IR: ir_sr_q <= {tdi_s_q, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR:   ir_q    <= ir_sr_q;
            CAP_DR: begin
              idcode_sr_q <= IDCODE_VALUE;
              bypass_q    <= 1'b0;
              cap_q       <= sel_debug;
            end
            SHIFT_DR: begin
              idcode_sr_q <= {tdi_s_q, idcode_sr_q[31:1]};
              bypass_q    <= tdi_s_q;
              shift_q     <= sel_debug;
            end
            UPD_DR:   upd_q <= sel_debug;
            default: ;
          endcase
          state_q <= next_state(state_q, tms_s_q);
        end
        // On the falling edge state_q already holds the post-transition state.
        if (tck_fall) begin
          unique case (state_q)
            SHIFT_IR: tdo_q <= ir_sr_q[0];
            SHIFT_DR: tdo_q <= sel_debug  ? dbg_tdo        :
                               sel_idcode ? idcode_sr_q[0] : bypass_q;
            default:  tdo_q <= 1'b0;
          endcase
        end
      end
    end
  end

  assign jtag_tdo       = tdo_q;
  assign tap_reset      = (state_q == TLR);
  assign dbg_select     = sel_debug;
  assign dbg_capture_dr = cap_q;
  assign dbg_shift_dr   = shift_q;
  assign dbg_update_dr  = upd_q;
  assign dbg_tdi        = dbg_tdi_q;

endmodule

// File: tb/tb_soc_riscv_dbg_jtag_tap.sv
module tb_soc_riscv_dbg_jtag_tap;

  logic clk = 1'b0;
  logic rst, jtag_trstn, jtag_tck, jtag_tms, jtag_tdi, dbg_tdo;
  logic jtag_tdo, tap_reset, dbg_select;
  logic dbg_capture_dr, dbg_shift_dr, dbg_update_dr, dbg_tdi;

  localparam logic [31:0] IDCODE = 32'h149511C3;

  soc_riscv_dbg_jtag_tap dut (
    .clk            (clk),
    .rst            (rst),
    .jtag_trstn     (jtag_trstn),
    .jtag_tck       (jtag_tck),
    .jtag_tms       (jtag_tms),
    .jtag_tdi       (jtag_tdi),
    .jtag_tdo       (jtag_tdo),
    .tap_reset      (tap_reset),
    .dbg_select     (dbg_select),
    .dbg_capture_dr (dbg_capture_dr),
    .dbg_shift_dr   (dbg_shift_dr),
    .dbg_update_dr  (dbg_update_dr),
    .dbg_tdi        (dbg_tdi),
    .dbg_tdo        (dbg_tdo)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   tdo_exp_q[$];
  bit   dbgtdi_exp_q[$];
  int   cap_cnt = 0, shf_cnt = 0, upd_cnt = 0;
  event sample_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // TDO monitor: pops one expected bit each time the host samples TDO.
  initial begin
    forever begin
      @(sample_ev);
      if (tdo_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tdo_underflow: got sample, expected none queued");
      end else begin
        check("tdo_bit", {31'd0, jtag_tdo}, {31'd0, tdo_exp_q.pop_front()});
      end
    end
  end

  // Debug strobe monitor: counts strobes, checks dbg_tdi against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (dbg_capture_dr) cap_cnt++;
      if (dbg_update_dr)  upd_cnt++;
      if (dbg_shift_dr) begin
        shf_cnt++;
        if (dbgtdi_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dbg_shift_unexpected: got strobe, expected none");
        end else begin
          check("dbg_tdi", {31'd0, dbg_tdi}, {31'd0, dbgtdi_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One TCK period: 6 clk low (TDO settles, host samples), 6 clk high.
  task automatic tck_pulse(input bit tms_v, input bit tdi_v, input bit smp, input bit exp_tdo);
    jtag_tms = tms_v;
    jtag_tdi = tdi_v;
    repeat (6) @(negedge clk);
    if (smp) begin
      tdo_exp_q.push_back(exp_tdo);
      -> sample_ev;
    end
    jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  // Full IR or DR scan from Run-Test/Idle back to Run-Test/Idle.
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      input logic [31:0] dexp, input bit dbg);
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (is_ir) tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (dbg) dbgtdi_exp_q.push_back(din[i]);
      tck_pulse(i == n - 1, din[i], 1'b1, dexp[i]);
    end
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
  endtask

  int c0, s0, u0;

  initial begin
    rst = 1'b1; jtag_trstn = 1'b1; jtag_tck = 1'b0;
    jtag_tms = 1'b1; jtag_tdi = 1'b0; dbg_tdo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tap_reset",  {31'd0, tap_reset},  32'd1);
    check("rst_tdo",        {31'd0, jtag_tdo},   32'd0);
    check("rst_dbg_select", {31'd0, dbg_select}, 32'd0);
    check("rst_strobes", {29'd0, dbg_capture_dr, dbg_shift_dr, dbg_update_dr}, 32'd0);
    check("rst_dbg_tdi",    {31'd0, dbg_tdi},    32'd0);

    // TLR -> RTI
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("rti_tap_reset", {31'd0, tap_reset}, 32'd0);

    // IDCODE read
    c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
    scan(1'b0, 32, 32'd0, IDCODE, 1'b0);
    check("idcode_no_strobes", c0 + s0 + u0, cap_cnt + shf_cnt + upd_cnt);

    // BYPASS: IR capture pattern out is 1,0,0,0; DR has a one-bit delay
    scan(1'b1, 4, 32'hF, 32'h1, 1'b0);
    check("bypass_dbg_select", {31'd0, dbg_select}, 32'd0);
    scan(1'b0, 4, 32'b1101, 32'b1010, 1'b0);

    // DEBUG path
    scan(1'b1, 4, 32'h8, 32'h1, 1'b0);
    check("debug_dbg_select", {31'd0, dbg_select}, 32'd1);
    dbg_tdo = 1'b1;
    c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
    scan(1'b0, 8, 32'hA5, 32'hFF, 1'b1);
    check("debug_capture_cnt", cap_cnt - c0, 32'd1);
    check("debug_shift_cnt",   shf_cnt - s0, 32'd8);
    check("debug_update_cnt",  upd_cnt - u0, 32'd1);
    dbg_tdo = 1'b0;

    // TMS reset from Pause-DR
    scan(1'b1, 4, 32'hF, 32'h1, 1'b0);
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("pause_tap_reset", {31'd0, tap_reset}, 32'd0);
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("tms_reset_tap_reset", {31'd0, tap_reset}, 32'd1);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    scan(1'b0, 32, 32'd0, IDCODE, 1'b0);

    // TRSTN in the middle of Shift-IR
    scan(1'b1, 4, 32'h8, 32'h1, 1'b0);
    check("pre_trst_dbg_select", {31'd0, dbg_select}, 32'd1);
    u0 = upd_cnt;
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tck_pulse(1'b0, 1'b1, 1'b0, 1'b0);
    jtag_trstn = 1'b0;
    repeat (4) @(negedge clk);
    jtag_trstn = 1'b1;
    settle();
    check("trst_tap_reset",  {31'd0, tap_reset},  32'd1);
    check("trst_dbg_select", {31'd0, dbg_select}, 32'd0);
    check("trst_no_update",  upd_cnt - u0,        32'd0);
    tck_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    scan(1'b0, 32, 32'd0, IDCODE, 1'b0);

    check("tdo_queue_drained",    tdo_exp_q.size(),    32'd0);
    check("dbgtdi_queue_drained", dbgtdi_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
